// File: rtl/hw_fifo_pkg.sv
// Request/response bundles exchanged with the streaming
// interface hardware FIFOs (one pair per DMA channel).
package hw_fifo_pkg;

    localparam int unsigned HW_FIFO_DW = 32;

    typedef struct packed {
        logic [HW_FIFO_DW-1:0] data;
        logic                  push;
        logic                  pop;
    } hw_fifo_req_t;

    typedef struct packed {
        logic [HW_FIFO_DW-1:0] data;
        logic                  empty;
        logic                  full;
        logic                  push;
    } hw_fifo_resp_t;

endpackage

// File: rtl/stream_intf_pkg.sv
// Shared types for the streaming interface DMA channel logic.
// Holds the per-channel transfer state encoding.
package stream_intf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dma_ch_state_e;

endpackage

// File: rtl/stream_dma_ch_fsm.sv
// Single DMA channel: IDLE/RUN/DONE FSM, word counter, handshake steering.
// Optional protocol error tracking under STREAM_DMA_ERR_CHK_EN.
module stream_dma_ch_fsm
    import hw_fifo_pkg::*;
    import stream_intf_pkg::*;
#(
    parameter int unsigned N_BITS = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              type_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              rx_valid_i,
    input  logic [N_BITS-1:0] rx_data_i,
    output logic              rx_ready_o,
    output logic              tx_valid_o,
    output logic [N_BITS-1:0] tx_data_o,
    input  logic              tx_ready_i,
    output hw_fifo_req_t      fifo_req_o,
    input  hw_fifo_resp_t     fifo_resp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    dma_ch_state_e    state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             start_ok;

    assign start_ok = (state_q == IDLE) && start_i;

    // State, remaining count and latched direction
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    // Next state, counting and combinational handshake steering
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dir_d      = dir_q;
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        fifo_req_o = '0;
        done_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    rem_d   = len_i;
                    dir_d   = type_i;
                    state_d = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!dir_q) begin
                    rx_ready_o      = !fifo_resp_i.full;
                    fifo_req_o.push = rx_valid_i && rx_ready_o;
                    fifo_req_o.data = rx_data_i;
                end else begin
                    tx_valid_o     = !fifo_resp_i.empty;
                    tx_data_o      = fifo_resp_i.data;
                    fifo_req_o.pop = tx_valid_o && tx_ready_i;
                end
                if (fifo_req_o.push || fifo_req_o.pop) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

`ifdef STREAM_DMA_ERR_CHK_EN
    logic err_q, err_d;
    logic run_rd, run_wr;

    assign run_rd = (state_q == RUN) && !dir_q;
    assign run_wr = (state_q == RUN) && dir_q;

    // Sticky error: cleared by an accepted start, set on a stray handshake
    always_comb begin
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end
        if ((rx_valid_i && !run_rd) || (fifo_resp_i.push && run_wr)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_err_in;

    assign unused_err_in = fifo_resp_i.push ^ start_ok;
    assign err_o         = 1'b0;
`endif

endmodule

// File: rtl/stream_dma_ch_ctrl.sv
// Array of independent DMA channel controllers between DMA and HW FIFOs.
// Optional error detection enabled with `define STREAM_DMA_ERR_CHK_EN.
module stream_dma_ch_ctrl
    import hw_fifo_pkg::*;
#(
    parameter int unsigned N_DMA_CH = 4,
    parameter int unsigned N_BITS   = 32,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [N_DMA_CH-1:0]              reg_dma_ch_type_i,
    input  logic [N_DMA_CH-1:0]              start_i,
    input  logic [N_DMA_CH-1:0][LEN_W-1:0]   len_i,
    input  logic [N_DMA_CH-1:0]              dma_rx_valid_i,
    input  logic [N_DMA_CH-1:0][N_BITS-1:0]  dma_rx_data_i,
    output logic [N_DMA_CH-1:0]              dma_rx_ready_o,
    output logic [N_DMA_CH-1:0]              dma_tx_valid_o,
    output logic [N_DMA_CH-1:0][N_BITS-1:0]  dma_tx_data_o,
    input  logic [N_DMA_CH-1:0]              dma_tx_ready_i,
    output hw_fifo_req_t [N_DMA_CH-1:0]      hw_fifo_req_o,
    input  hw_fifo_resp_t [N_DMA_CH-1:0]     hw_fifo_resp_i,
    output logic [N_DMA_CH-1:0]              busy_o,
    output logic [N_DMA_CH-1:0]              done_o,
    output logic [N_DMA_CH-1:0]              err_o
);

    for (genvar i = 0; i < N_DMA_CH; i++) begin : g_ch
        stream_dma_ch_fsm #(
            .N_BITS (N_BITS),
            .LEN_W  (LEN_W)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .type_i      (reg_dma_ch_type_i[i]),
            .start_i     (start_i[i]),
            .len_i       (len_i[i]),
            .rx_valid_i  (dma_rx_valid_i[i]),
            .rx_data_i   (dma_rx_data_i[i]),
            .rx_ready_o  (dma_rx_ready_o[i]),
            .tx_valid_o  (dma_tx_valid_o[i]),
            .tx_data_o   (dma_tx_data_o[i]),
            .tx_ready_i  (dma_tx_ready_i[i]),
            .fifo_req_o  (hw_fifo_req_o[i]),
            .fifo_resp_i (hw_fifo_resp_i[i]),
            .busy_o      (busy_o[i]),
            .done_o      (done_o[i]),
            .err_o       (err_o[i])
        );
    end

endmodule

// File: tb/tb_stream_dma_ch_ctrl.sv
// Bench for stream_dma_ch_ctrl: scoreboarded read/write channel scenarios.
// Honours STREAM_DMA_ERR_CHK_EN for the err_o expectations.
module tb_stream_dma_ch_ctrl;
    import hw_fifo_pkg::*;

    localparam int NC = 4;
    localparam int NB = 32;
    localparam int LW = 16;
`ifdef STREAM_DMA_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NC-1:0]         type_r, start, rx_valid, rx_ready;
    logic [NC-1:0]         tx_valid, tx_ready, busy, done, err;
    logic [NC-1:0][LW-1:0] len;
    logic [NC-1:0][NB-1:0] rx_data, tx_data;
    hw_fifo_req_t  [NC-1:0] req;
    hw_fifo_resp_t [NC-1:0] resp;

    int total = 0;
    int bad   = 0;
    logic [NB-1:0] sb[$];

    always #5 clk = ~clk;

    stream_dma_ch_ctrl #(
        .N_DMA_CH (NC),
        .N_BITS   (NB),
        .LEN_W    (LW)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .reg_dma_ch_type_i (type_r),
        .start_i           (start),
        .len_i             (len),
        .dma_rx_valid_i    (rx_valid),
        .dma_rx_data_i     (rx_data),
        .dma_rx_ready_o    (rx_ready),
        .dma_tx_valid_o    (tx_valid),
        .dma_tx_data_o     (tx_data),
        .dma_tx_ready_i    (tx_ready),
        .hw_fifo_req_o     (req),
        .hw_fifo_resp_i    (resp),
        .busy_o            (busy),
        .done_o            (done),
        .err_o             (err)
    );

    task automatic test_reset();
        rst_n    = 1'b0;
        type_r   = '0;
        start    = '0;
        len      = '0;
        rx_valid = '0;
        rx_data  = '0;
        tx_ready = '0;
        for (int i = 0; i < NC; i++) begin
            resp[i] = '0;
            resp[i].empty = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({busy, done, err, rx_ready, tx_valid} !== '0) begin
            bad++;
            $display("FAIL reset_ctl got=%h want=0",
                     {busy, done, err, rx_ready, tx_valid});
        end
        total++;
        if (req !== '0 || tx_data !== '0) begin
            bad++;
            $display("FAIL reset_data got req=%h tx=%h want=0", req, tx_data);
        end
        rst_n = 1'b1;
    endtask

    // Read channel run with optional FIFO full window and ignored restart.
    task automatic run_read(input int ch, input int n, input int full_after,
                            input int full_cnt, input int restart_at,
                            input string nm);
        int pushes = 0;
        int last = -1;
        int done_c = -1;
        int full_left = 0;
        int low_cnt = 0;
        logic full_now;
        logic exp_rdy;
        logic [NB-1:0] exp;
        logic [NB-1:0] base;
        base = 32'hD000 + NB'(ch) * 32'h100;
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back(base + NB'(i));
        @(negedge clk);
        start[ch]  = 1'b1;
        len[ch]    = LW'(n);
        type_r[ch] = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start[ch] = (c == restart_at);
            if (c == restart_at) len[ch] = LW'(3);
            full_now = (full_left > 0);
            resp[ch].full = full_now;
            rx_valid[ch]  = 1'b1;
            rx_data[ch]   = base + NB'(pushes);
            #1;
            exp_rdy = (pushes < n) && !full_now;
            if (pushes < n && !full_now) low_cnt = low_cnt;
            if (pushes < n && full_now) low_cnt++;
            total++;
            if (rx_ready[ch] !== exp_rdy) begin
                bad++;
                $display("FAIL %s ready c=%0d got=%b want=%b",
                         nm, c, rx_ready[ch], exp_rdy);
            end
            if (req[ch].push === 1'b1) begin
                total++;
                if (pushes >= n || full_now) begin
                    bad++;
                    $display("FAIL %s extra_push c=%0d got=1 want=0", nm, c);
                end else begin
                    exp = sb.pop_front();
                    total++;
                    if (req[ch].data !== exp) begin
                        bad++;
                        $display("FAIL %s data got=%h want=%h",
                                 nm, req[ch].data, exp);
                    end
                end
                pushes++;
                last = c;
                if (pushes == full_after) full_left = full_cnt + 1;
            end
            if (full_left > 0) full_left--;
            if (done[ch] === 1'b1) begin
                total++;
                if (c != last + 1) begin
                    bad++;
                    $display("FAIL %s done_time got=%0d want=%0d",
                             nm, c, last + 1);
                end
                done_c = c;
            end else if (done_c >= 0 && c == done_c + 1) begin
                total++;
                if (busy[ch] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s busy_after got=%b want=0", nm, busy[ch]);
                end
                break;
            end
        end
        total++;
        if (done_c < 0) begin
            bad++;
            $display("FAIL %s timeout got=no_done want=done", nm);
        end
        total++;
        if (pushes != n) begin
            bad++;
            $display("FAIL %s push_count got=%0d want=%0d", nm, pushes, n);
        end
        total++;
        if (low_cnt != full_cnt) begin
            bad++;
            $display("FAIL %s ready_low got=%0d want=%0d", nm, low_cnt, full_cnt);
        end
        @(negedge clk);
        rx_valid[ch]  = 1'b0;
        start[ch]     = 1'b0;
        resp[ch].full = 1'b0;
    endtask

    task automatic test_read_burst();
        run_read(0, 8, -1, 0, -1, "read_burst");
    endtask

    task automatic test_back_pressure();
        run_read(1, 6, 2, 3, -1, "backpress");
    endtask

    task automatic test_ignored_start();
        run_read(3, 5, -1, 0, 1, "ign_start");
    endtask

    task automatic test_write();
        logic [NB-1:0] fifo[$];
        logic [NB-1:0] exp;
        logic tgl = 1'b1;
        logic exp_v;
        int pops = 0;
        int last = -1;
        int done_c = -1;
        sb.delete();
        for (int i = 0; i < 6; i++) fifo.push_back(32'hA0 + NB'(i));
        for (int i = 0; i < 5; i++) sb.push_back(32'hA0 + NB'(i));
        @(negedge clk);
        start[2]  = 1'b1;
        len[2]    = LW'(5);
        type_r[2] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start[2]      = 1'b0;
            type_r[2]     = c[0];
            resp[2].empty = (fifo.size() == 0);
            resp[2].data  = (fifo.size() > 0) ? fifo[0] : '0;
            tx_ready[2]   = tgl;
            #1;
            exp_v = (pops < 5) && (fifo.size() > 0);
            total++;
            if (tx_valid[2] !== exp_v) begin
                bad++;
                $display("FAIL write valid c=%0d got=%b want=%b",
                         c, tx_valid[2], exp_v);
            end
            if (req[2].pop === 1'b1) begin
                total++;
                if (!tgl || pops >= 5) begin
                    bad++;
                    $display("FAIL write bad_pop c=%0d got=1 want=0", c);
                end else begin
                    exp = sb.pop_front();
                    total++;
                    if (tx_data[2] !== exp) begin
                        bad++;
                        $display("FAIL write data got=%h want=%h",
                                 tx_data[2], exp);
                    end
                end
                void'(fifo.pop_front());
                pops++;
                last = c;
            end
            if (done[2] === 1'b1) begin
                total++;
                if (c != last + 1) begin
                    bad++;
                    $display("FAIL write done_time got=%0d want=%0d",
                             c, last + 1);
                end
                done_c = c;
                break;
            end
            tgl = ~tgl;
        end
        total++;
        if (done_c < 0 || pops != 5) begin
            bad++;
            $display("FAIL write count got=%0d want=5 done=%0d", pops, done_c);
        end
        total++;
        if (fifo.size() != 1) begin
            bad++;
            $display("FAIL write left got=%0d want=1", fifo.size());
        end
        @(negedge clk);
        tx_ready[2]   = 1'b0;
        resp[2].empty = 1'b1;
        type_r[2]     = 1'b0;
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start[1]  = 1'b1;
        len[1]    = '0;
        type_r[1] = 1'b0;
        @(negedge clk);
        start[1] = 1'b0;
        #1;
        total++;
        if (done[1] !== 1'b1 || busy[1] !== 1'b1) begin
            bad++;
            $display("FAIL zero_done got=%b%b want=11", done[1], busy[1]);
        end
        total++;
        if (req[1].push !== 1'b0 || req[1].pop !== 1'b0) begin
            bad++;
            $display("FAIL zero_xfer got=%b%b want=00", req[1].push, req[1].pop);
        end
        @(negedge clk);
        #1;
        total++;
        if (done[1] !== 1'b0 || busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL zero_idle got=%b%b want=00", done[1], busy[1]);
        end
    endtask

    task automatic test_reset_mid();
        int pushes = 0;
        @(negedge clk);
        start[0]  = 1'b1;
        len[0]    = LW'(10);
        type_r[0] = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 20 && pushes < 2; c++) begin
            @(negedge clk);
            start[0]    = 1'b0;
            rx_valid[0] = 1'b1;
            rx_data[0]  = 32'hE0 + NB'(c);
            #1;
            if (req[0].push === 1'b1) pushes++;
        end
        total++;
        if (pushes != 2) begin
            bad++;
            $display("FAIL rst_mid pre got=%0d want=2", pushes);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({busy, done, err, rx_ready, tx_valid} !== '0 || req !== '0) begin
            bad++;
            $display("FAIL rst_mid outs got=%h req=%h want=0",
                     {busy, done, err, rx_ready, tx_valid}, req);
        end
        rst_n       = 1'b1;
        rx_valid[0] = 1'b0;
        run_read(0, 4, -1, 0, -1, "rst_mid_new");
    endtask

    task automatic test_err();
        @(negedge clk);
        rx_valid[1] = 1'b1;
        @(negedge clk);
        rx_valid[1] = 1'b0;
        #1;
        total++;
        if (err[1] !== ERR_EN) begin
            bad++;
            $display("FAIL err_set got=%b want=%b", err[1], ERR_EN);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (err[1] !== ERR_EN) begin
            bad++;
            $display("FAIL err_hold got=%b want=%b", err[1], ERR_EN);
        end
        @(negedge clk);
        start[1]  = 1'b1;
        len[1]    = '0;
        type_r[1] = 1'b0;
        @(negedge clk);
        start[1] = 1'b0;
        #1;
        total++;
        if (err[1] !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%b want=0", err[1]);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_back_pressure();
        test_write();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
